// File: rtl/fetch_branch_redirect_pkg.sv
// Shared definitions for the fetch-side branch redirect controller:
// state encoding, resolved-event kinds, instruction size and alignment helper.
package fetch_branch_redirect_pkg;

  typedef enum logic [1:0] {
    FBR_INIT  = 2'd0,
    FBR_RUN   = 2'd1,
    FBR_FLUSH = 2'd2,
    FBR_HALT  = 2'd3
  } fbr_state_t;

  typedef enum logic [2:0] {
    FBR_EV_NONE = 3'd0,
    FBR_EV_SEQ  = 3'd1,
    FBR_EV_JUMP = 3'd2,
    FBR_EV_IB   = 3'd3,
    FBR_EV_HALT = 3'd4
  } fbr_event_t;

  localparam logic [31:0] FBR_INSN_SIZE  = 32'h0000_0004;
  localparam logic [31:0] FBR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] fbr_align(input logic [31:0] addr);
    return addr & FBR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_branch_redirect.sv
// Owns the fetch PC: issues sequential fetches, and on taken branch, interrupt
// branch or HALT from execute performs a one-cycle flush and redirects fetch.
module fetch_branch_redirect
  import fetch_branch_redirect_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000,
  parameter int          P_CNT_W    = 16
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic               iEXE_VALID,
  input  logic               iEXE_JUMP_VALID,
  input  logic               iEXE_NOT_JUMP_VALID,
  input  logic               iEXE_IB_VALID,
  input  logic               iEXE_HALT_VALID,
  input  logic [31:0]        iEXE_BRANCH_ADDR,
  input  logic [31:0]        iEXE_PC,
  input  logic [31:0]        iIB_ADDR,
  input  logic               iRESUME,
  input  logic               iFETCH_LOCK,
  output logic               oFETCH_REQ,
  output logic [31:0]        oFETCH_ADDR,
  output logic               oFLUSH,
  output logic               oEXE_LOCK,
  output logic               oHALTED,
  output logic               oMISALIGN,
  output logic [P_CNT_W-1:0] oREDIRECT_CNT
);

  localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

  fbr_state_t         state;
  logic [31:0]        pc;
  logic               halt_pend;
  logic               flush;
  logic               misalign;
  logic [P_CNT_W-1:0] cnt;

  fbr_event_t  ev;
  logic        redirect;
  logic [31:0] raw_target;
  logic        target_misaligned;

  // Priority decode of the execute result; only meaningful while running.
  always_comb begin
    ev = FBR_EV_NONE;
    if (state == FBR_RUN && iEXE_VALID) begin
      casez ({iEXE_HALT_VALID, iEXE_IB_VALID, iEXE_JUMP_VALID, iEXE_NOT_JUMP_VALID})
        4'b1???: ev = FBR_EV_HALT;
        4'b01??: ev = FBR_EV_IB;
        4'b001?: ev = FBR_EV_JUMP;
        4'b0001: ev = FBR_EV_SEQ;
        default: ev = FBR_EV_NONE;
      endcase
    end
  end

  always_comb begin
    raw_target = iEXE_BRANCH_ADDR;
    redirect   = 1'b0;
    case (ev)
      FBR_EV_HALT: begin raw_target = iEXE_PC + FBR_INSN_SIZE; redirect = 1'b1; end
      FBR_EV_IB:   begin raw_target = iIB_ADDR;                redirect = 1'b1; end
      FBR_EV_JUMP: begin raw_target = iEXE_BRANCH_ADDR;        redirect = 1'b1; end
      default:     begin raw_target = iEXE_BRANCH_ADDR;        redirect = 1'b0; end
    endcase
    target_misaligned = (ev == FBR_EV_IB || ev == FBR_EV_JUMP) && (raw_target[1:0] != 2'b00);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state     <= FBR_INIT;
      pc        <= P_RESET_PC;
      halt_pend <= 1'b0;
      flush     <= 1'b0;
      misalign  <= 1'b0;
      cnt       <= '0;
    end else if (iRESET_SYNC) begin
      state     <= FBR_INIT;
      pc        <= P_RESET_PC;
      halt_pend <= 1'b0;
      flush     <= 1'b0;
      misalign  <= 1'b0;
      cnt       <= '0;
    end else begin
      flush    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        FBR_INIT: state <= FBR_RUN;
        FBR_RUN: begin
          // A redirect overrides any sequential increment in the same cycle.
          if (redirect) begin
            state     <= FBR_FLUSH;
            pc        <= fbr_align(raw_target);
            flush     <= 1'b1;
            misalign  <= target_misaligned;
            cnt       <= cnt + CNT_ONE;
            halt_pend <= (ev == FBR_EV_HALT);
          end else if (!iFETCH_LOCK) begin
            pc <= pc + FBR_INSN_SIZE;
          end
        end
        FBR_FLUSH: begin
          state     <= halt_pend ? FBR_HALT : FBR_RUN;
          halt_pend <= 1'b0;
        end
        FBR_HALT: if (iRESUME) state <= FBR_RUN;
        default:  state <= FBR_INIT;
      endcase
    end
  end

  assign oFETCH_REQ    = (state == FBR_RUN);
  assign oFETCH_ADDR   = pc;
  assign oFLUSH        = flush;
  assign oEXE_LOCK     = (state == FBR_INIT) || (state == FBR_FLUSH) || (state == FBR_HALT);
  assign oHALTED       = (state == FBR_HALT);
  assign oMISALIGN     = misalign;
  assign oREDIRECT_CNT = cnt;

endmodule
